seq_div_32: RTL and testbench

SEQ_DIV_32 -- requirements
Module: seq_div_32

---
 rtl/seq_div_32_pkg.sv | 21 ++
 rtl/seq_div_32_div_step.sv | 22 ++
 rtl/seq_div_32.sv | 125 ++++++++++++
 tb/tb_seq_div_32.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_div_32_pkg.sv
// Shared widths, FSM encoding and iteration-counter sizing for the sequential
// 32/16 restoring divider.
package seq_div_32_pkg;

    localparam int M = 16;
    localparam int N = 32;

    // The counter needs one spare bit so it can hold the full iteration count m.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = cnt_width(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_32_div_step.sv
// One restoring-division step: conditional subtract of the divisor from an
// (m+1)-bit partial remainder that already has the next dividend bit shifted in.
module div_step
    import seq_div_32_pkg::*;
#(
    parameter int m = M
) (
    input  logic [m:0]   rem_in,
    input  logic [m-1:0] divisor,
    output logic [m:0]   rem_out,
    output logic         q_bit
);

    logic [m+1:0] diff;

    // Both operands are below 2^(m+1), so the top bit of the widened
    // difference is a clean borrow flag.
    assign diff    = {1'b0, rem_in} - {2'b00, divisor};
    assign q_bit   = ~diff[m+1];
    assign rem_out = q_bit ? diff[m:0] : rem_in;

endmodule

// File: rtl/seq_div_32.sv
// Sequential unsigned n/m divider with valid/ready handshakes. Quotient bits
// are produced MSB first, one per cycle, sharing a shift register with the dividend.
module seq_div_32
    import seq_div_32_pkg::*;
#(
    parameter int m = M,
    parameter int n = N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [m-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [m-1:0] Q,
    output logic [m-1:0] R,
    output logic         div_zero,
    output logic         ovf
);

    localparam int cw = cnt_width(m);

    state_t       state_reg;
    logic [cw-1:0] cnt_reg;
    logic [m:0]   pr_reg;
    logic [m-1:0] a_reg;
    logic [m-1:0] b_reg;
    logic [m-1:0] q_reg;
    logic [m-1:0] r_reg;
    logic         out_valid_reg;
    logic         div_zero_reg;
    logic         ovf_reg;

    logic [m:0]   step_in;
    logic [m:0]   step_rem;
    logic         step_q;

    // a_reg holds the not-yet-consumed dividend bits in its upper part and
    // the quotient bits produced so far in its lower part.
    assign step_in = {pr_reg[m-1:0], a_reg[m-1]};

    div_step #(.m(m)) u_step (
        .rem_in  (step_in),
        .divisor (b_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign Q         = q_reg;
    assign R         = r_reg;
    assign div_zero  = div_zero_reg;
    assign ovf       = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pr_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            out_valid_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (B == '0) begin
                            q_reg         <= '1;
                            r_reg         <= A[m-1:0];
                            div_zero_reg  <= 1'b1;
                            ovf_reg       <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else if (A[n-1:m] >= B) begin
                            // Upper half already >= divisor: quotient needs more than m bits.
                            q_reg         <= '1;
                            r_reg         <= A[m-1:0];
                            div_zero_reg  <= 1'b0;
                            ovf_reg       <= 1'b1;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            pr_reg        <= {1'b0, A[n-1:m]};
                            a_reg         <= A[m-1:0];
                            b_reg         <= B;
                            cnt_reg       <= '0;
                            div_zero_reg  <= 1'b0;
                            ovf_reg       <= 1'b0;
                            state_reg     <= CALC;
                        end
                    end
                end
                CALC: begin
                    pr_reg  <= step_rem;
                    a_reg   <= {a_reg[m-2:0], step_q};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == cw'(m - 1)) begin
                        q_reg         <= {a_reg[m-2:0], step_q};
                        r_reg         <= step_rem[m-1:0];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: expected results are queued at accept and
// compared when out_valid appears, together with latency and handshake behaviour.
module tb_seq_div_32;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [15:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] Q;
    logic [15:0] R;
    logic        div_zero;
    logic        ovf;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    seq_div_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] bw;
        bw = {16'd0, b};
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a[15:0]; e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
        end else if ({16'd0, a[31:16]} >= bw) begin
            e.q = 16'hFFFF; e.r = a[15:0]; e.dz = 1'b0; e.ov = 1'b1; e.lat = 1;
        end else begin
            e.q = 16'(a / bw); e.r = 16'(a % bw); e.dz = 1'b0; e.ov = 1'b0; e.lat = 17;
        end
        return e;
    endfunction

    // Drive one operation, then check its result after 'stall' cycles of out_ready low.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int stall);
        int   cyc;
        exp_t e;
        logic [15:0] hq;
        logic [15:0] hr;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = 16'($urandom);
        cyc = 1;
        check_eq("in_ready_busy", 64'(in_ready), 64'd0);
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check_eq("out_valid_seen", 64'(out_valid), 64'd1);
        check_eq("latency", 64'(cyc), 64'(e.lat));
        check_eq("Q", 64'(Q), 64'(e.q));
        check_eq("R", 64'(R), 64'(e.r));
        check_eq("div_zero", 64'(div_zero), 64'(e.dz));
        check_eq("ovf", 64'(ovf), 64'(e.ov));
        if (stall > 0) begin
            out_ready = 1'b0;
            hq = Q; hr = R;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_Q", 64'(Q), 64'(e.q));
                check_eq("hold_R", 64'(R), 64'(e.r));
                check_eq("hold_in_ready", 64'(in_ready), 64'd0);
                check_eq("hold_Q_stable", 64'(Q), 64'(hq));
                check_eq("hold_R_stable", 64'(R), 64'(hr));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("post_hs_out_valid", 64'(out_valid), 64'd0);
        check_eq("post_hs_in_ready", 64'(in_ready), 64'd1);
        $display("op A=%h B=%h -> Q=%h R=%h dz=%0b ovf=%0b lat=%0d", a, b, e.q, e.r, e.dz, e.ov, cyc);
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        logic [15:0] hi;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_Q", 64'(Q), 64'd0);
        check_eq("rst_R", 64'(R), 64'd0);
        check_eq("rst_flags", 64'({div_zero, ovf}), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_release_in_ready", 64'(in_ready), 64'd1);

        run_op(32'd1000, 16'd7, 0);
        run_op(32'hFFFE0001, 16'hFFFF, 0);
        run_op(32'd5, 16'd0, 0);
        run_op(32'h00070000, 16'd7, 0);
        run_op(32'd100, 16'd9, 5);

        // Abandon an operation mid-CALC with a reset pulse.
        @(negedge clk);
        A = 32'd1000; B = 16'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midcalc_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_eq("midcalc_rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("midcalc_release_in_ready", 64'(in_ready), 64'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check_eq("no_out_valid_after_rst", 64'(seen), 64'd0);
        end
        $display("op reset mid-CALC abandoned");

        run_op(32'd1000, 16'd7, 0);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = 16'($urandom_range(0, 65535));
            if (k % 7 == 3) rb = 16'd0;
            if (rb != 16'd0 && (k % 4) != 0) begin
                hi = ra[31:16] % rb;
                ra = {hi, ra[15:0]};
            end
            run_op(ra, rb, k % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
